// File: rtl/pe_accum_bank_if.sv
// Beat-in / group-out handshake bundle for pe_accum_bank.
// master drives the beats and out_ready; slave is the accumulator bank.
`timescale 1ns/1ps
interface pe_accum_bank_if #(
  parameter int NUM_CH  = 4,
  parameter int IN_W    = 20,
  parameter int ACC_W   = 32,
  parameter int SHIFT_W = 3,
  parameter int CNT_W   = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_first;
  logic                    in_last;
  logic [SHIFT_W-1:0]      in_shift;
  logic [NUM_CH*IN_W-1:0]  in_sum;
  logic                    out_valid;
  logic                    out_ready;
  logic [NUM_CH*ACC_W-1:0] out_sum;
  logic [NUM_CH-1:0]       out_sat;
  logic [CNT_W-1:0]        out_beats;
  logic                    err_restart;

  modport master (
    output in_valid, in_first, in_last, in_shift, in_sum, out_ready,
    input  in_ready, out_valid, out_sum, out_sat, out_beats, err_restart
  );

  modport slave (
    input  in_valid, in_first, in_last, in_shift, in_sum, out_ready,
    output in_ready, out_valid, out_sum, out_sat, out_beats, err_restart
  );
endinterface

// File: rtl/pe_accum_bank.sv
// Multi-lane saturating accumulator for shifted PE partial sums, grouped by
// first/last markers, with a valid/ready output register for the finished group.
`timescale 1ns/1ps
module pe_accum_bank #(
  parameter int NUM_CH  = 4,
  parameter int IN_W    = 20,
  parameter int ACC_W   = 32,
  parameter int SHIFT_W = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  pe_accum_bank_if.slave   bus
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                        state_q, state_d;
  logic [NUM_CH-1:0][ACC_W-1:0]  acc_q, acc_d, acc_next;
  logic [NUM_CH-1:0][ACC_W-1:0]  out_sum_q, out_sum_d;
  logic [NUM_CH-1:0]             sat_q, sat_d, sat_next;
  logic [NUM_CH-1:0]             out_sat_q, out_sat_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d, cnt_next;
  logic [CNT_W-1:0]              out_beats_q, out_beats_d;
  logic                          out_valid_q, out_valid_d;
  logic                          err_q, err_d;
  logic                          in_ready, in_xfer, fresh;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign in_xfer  = bus.in_valid && in_ready;
  // A beat starts a new group when none is open or when it carries in_first.
  assign fresh    = (state_q == IDLE) || bus.in_first;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    logic [ACC_W-1:0] ext_sum;
    logic [ACC_W-1:0] term;
    logic [ACC_W:0]   wide;
    logic             ovf;

    assign ext_sum = {{(ACC_W-IN_W){bus.in_sum[g*IN_W+IN_W-1]}}, bus.in_sum[g*IN_W +: IN_W]};
    assign term    = ext_sum << bus.in_shift;
    assign wide    = {acc_q[g][ACC_W-1], acc_q[g]} + {term[ACC_W-1], term};
    // Overflow when the extra sign bit disagrees with the ACC_W-bit sign.
    assign ovf     = wide[ACC_W] != wide[ACC_W-1];
    assign acc_next[g] = fresh ? term :
                         ovf   ? (wide[ACC_W] ? ACC_MIN : ACC_MAX) :
                                 wide[ACC_W-1:0];
    assign sat_next[g] = !fresh && (sat_q[g] || ovf);
  end

  assign cnt_next = fresh   ? CNT_W'(1) :
                    (&cnt_q) ? cnt_q    : cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    cnt_d       = cnt_q;
    out_sum_d   = out_sum_q;
    out_sat_d   = out_sat_q;
    out_beats_d = out_beats_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    err_d       = 1'b0;
    if (in_xfer) begin
      err_d = (state_q == ACCUM) && bus.in_first;
      if (bus.in_last) begin
        out_sum_d   = acc_next;
        out_sat_d   = sat_next;
        out_beats_d = cnt_next;
        out_valid_d = 1'b1;
        acc_d       = '0;
        sat_d       = '0;
        cnt_d       = '0;
        state_d     = IDLE;
      end else begin
        acc_d   = acc_next;
        sat_d   = sat_next;
        cnt_d   = cnt_next;
        state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      sat_q       <= '0;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      out_sat_q   <= '0;
      out_beats_q <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      cnt_q       <= cnt_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
      out_beats_q <= out_beats_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_sum     = out_sum_q;
  assign bus.out_sat     = out_sat_q;
  assign bus.out_beats   = out_beats_q;
  assign bus.err_restart = err_q;

endmodule

// File: tb/tb_pe_accum_bank.sv
// Scoreboard bench for pe_accum_bank: a group-level integer model predicts each
// finished group; a monitor pops and compares whenever a result is consumed.
`timescale 1ns/1ps
module tb_pe_accum_bank;
  localparam int NUM_CH  = 4;
  localparam int IN_W    = 20;
  localparam int ACC_W   = 32;
  localparam int SHIFT_W = 3;
  localparam int CNT_W   = 8;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  typedef struct {
    logic [NUM_CH*ACC_W-1:0] sum;
    logic [NUM_CH-1:0]       sat;
    logic [CNT_W-1:0]        beats;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  res_t   sb[$];
  res_t   mon_e;
  longint m_acc[NUM_CH];
  bit     m_sat[NUM_CH];
  int     m_cnt;
  bit     m_open;
  bit     exp_valid;
  bit     exp_err;

  pe_accum_bank_if #(.NUM_CH(NUM_CH), .IN_W(IN_W), .ACC_W(ACC_W),
                     .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)) bus ();

  pe_accum_bank #(.NUM_CH(NUM_CH), .IN_W(IN_W), .ACC_W(ACC_W),
                  .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [NUM_CH*IN_W-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [NUM_CH*IN_W-1:0] v;
    v[0*IN_W +: IN_W] = a[IN_W-1:0];
    v[1*IN_W +: IN_W] = b[IN_W-1:0];
    v[2*IN_W +: IN_W] = c[IN_W-1:0];
    v[3*IN_W +: IN_W] = d[IN_W-1:0];
    return v;
  endfunction

  // Group-level reference: integer accumulation with clamping to the signed 32-bit range.
  function automatic void modelBeat(input bit f, input bit l, input int sh, input logic [NUM_CH*IN_W-1:0] s);
    bit     fresh;
    longint term;
    res_t   r;
    fresh   = !m_open || f;
    exp_err = m_open && f;
    for (int i = 0; i < NUM_CH; i++) begin
      term = longint'($signed(s[i*IN_W +: IN_W])) * (64'sd1 << sh);
      if (fresh) begin
        m_acc[i] = term;
        m_sat[i] = 1'b0;
      end else begin
        m_acc[i] = m_acc[i] + term;
        if (m_acc[i] > MAXV) begin m_acc[i] = MAXV; m_sat[i] = 1'b1; end
        if (m_acc[i] < MINV) begin m_acc[i] = MINV; m_sat[i] = 1'b1; end
      end
    end
    m_cnt = fresh ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    if (l) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r.sum[i*ACC_W +: ACC_W] = m_acc[i][ACC_W-1:0];
        r.sat[i] = m_sat[i];
      end
      r.beats   = m_cnt[CNT_W-1:0];
      sb.push_back(r);
      m_open    = 1'b0;
      exp_valid = 1'b1;
    end else begin
      m_open = 1'b1;
    end
  endfunction

  task automatic applyStimulus(input bit v, input bit f, input bit l, input int sh,
                               input logic [NUM_CH*IN_W-1:0] s);
    bit take, xfer;
    bus.in_valid = v;
    bus.in_first = f;
    bus.in_last  = l;
    bus.in_shift = sh[SHIFT_W-1:0];
    bus.in_sum   = s;
    @(negedge clk);
    checkOutput("in_ready", bus.in_ready, !exp_valid || bus.out_ready);
    take = v && (!exp_valid || bus.out_ready);
    xfer = exp_valid && bus.out_ready;
    @(posedge clk);
    exp_err = 1'b0;
    if (xfer) exp_valid = 1'b0;
    if (take) modelBeat(f, l, sh, s);
    #1;
    checkOutput("err_restart", bus.err_restart, exp_err);
    checkOutput("out_valid", bus.out_valid, exp_valid);
  endtask

  task automatic modelReset();
    m_open    = 1'b0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    sb.delete();
  endtask

  // Monitor: every consumed result must match the oldest predicted group.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_result actual=%0h expected=none", bus.out_sum);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("out_sum", bus.out_sum, mon_e.sum);
          checkOutput("out_sat", bus.out_sat, mon_e.sat);
          checkOutput("out_beats", bus.out_beats, mon_e.beats);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [95:0] rnd;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_first  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_shift  = '0;
    bus.in_sum    = '0;
    bus.out_ready = 1'b1;
    modelReset();
    m_cnt = 0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_sum", bus.out_sum, 0);
    checkOutput("rst_out_sat", bus.out_sat, 0);
    checkOutput("rst_out_beats", bus.out_beats, 0);
    checkOutput("rst_err", bus.err_restart, 0);
    checkOutput("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] one-beat group");
    applyStimulus(1, 1, 1, 0, pack4(5, 0, 0, 0));
    applyStimulus(0, 0, 0, 0, '0);

    $display("[TB] four-beat shifted group");
    for (int k = 0; k < 4; k++)
      applyStimulus(1, k == 0, k == 3, k, pack4(0, 3, 0, 0));
    applyStimulus(0, 0, 0, 0, '0);

    $display("[TB] positive and negative saturation");
    for (int k = 0; k < 301; k++)
      applyStimulus(1, k == 0, k == 300, 7, pack4(1, 0, 524287, 0));
    for (int k = 0; k < 40; k++)
      applyStimulus(1, k == 0, k == 39, 7, pack4(0, -3, -524288, 2));
    applyStimulus(0, 0, 0, 0, '0);

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    applyStimulus(1, 1, 1, 0, pack4(11, 12, 13, 14));
    checkOutput("held_count", sb.size(), 1);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, 0, 0, 1, pack4(100, 100, 100, 100));
      checkOutput("held_sum", bus.out_sum, sb[0].sum);
    end
    bus.out_ready = 1'b1;
    applyStimulus(1, 1, 1, 0, pack4(-7, 0, 0, 0));
    applyStimulus(0, 0, 0, 0, '0);

    $display("[TB] restart inside a group");
    applyStimulus(1, 1, 0, 0, pack4(10, 0, 0, 0));
    applyStimulus(1, 0, 0, 0, pack4(20, 0, 0, 0));
    applyStimulus(1, 1, 0, 0, pack4(1, 0, 0, 0));
    applyStimulus(1, 0, 1, 0, pack4(2, 0, 0, 0));
    applyStimulus(0, 0, 0, 0, '0);

    $display("[TB] asynchronous reset mid-group and with a held result");
    applyStimulus(1, 1, 0, 0, pack4(50, 60, 70, 80));
    applyStimulus(1, 0, 0, 0, pack4(50, 60, 70, 80));
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput("midrst_out_valid", bus.out_valid, 0);
    checkOutput("midrst_out_beats", bus.out_beats, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    applyStimulus(1, 1, 1, 0, pack4(9, 0, 0, 0));
    applyStimulus(0, 0, 0, 0, '0);
    bus.out_ready = 1'b0;
    applyStimulus(1, 1, 1, 0, pack4(33, 0, 0, 0));
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput("heldrst_out_valid", bus.out_valid, 0);
    checkOutput("heldrst_out_sum", bus.out_sum, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    bus.out_ready = 1'b1;

    $display("[TB] randomized traffic");
    for (int k = 0; k < 400; k++) begin
      rnd = {$urandom, $urandom, $urandom};
      bus.out_ready = ($urandom % 4) != 0;
      applyStimulus(($urandom % 4) != 0, ($urandom % 6) == 0, ($urandom % 5) == 0,
                    int'($urandom % 8), rnd[NUM_CH*IN_W-1:0]);
    end

    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++)
      if (sb.size() != 0) applyStimulus(0, 0, 0, 0, '0);
    checkOutput("drain_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
